power_pulse_gen: RTL
====================

# power_pulse_gen

Programmable energy-pulse generator for the power-meter calibration path. Produces a 50 % duty-cycle pulse train on `pulse_out` whose half-period is set in clkin cycles (10 ns each at 100 MHz) by the CPU. Optionally stops after a programmed number of pulses. It sits directly upstream of the pulse-width measurement input and drives the same pulse line that block measures (loop-back self-test and standard-source emulation).

## Interface
Parameters:
- `INTRPT_LEN`, default 9: length of the `intrpt` pulse, in clkin cycles.

Ports:
- `clkin`  in  1  clock, 100 MHz.
- `rst_n`  in  1  reset, synchronous, active-low.
- `enable`  in  1  run request. High starts or continues generation; low aborts.
- `half_period`  in  32  high time and low time, in clkin cycles. 0 is treated as 1.
- `pulse_num`  in  32  burst length in pulses. 0 means free-run.
- `pulse_out`  out  1  generated pulse, registered.
- `pulse_cnt`  out  32  pulses completed since the last start.
- `busy`  out  1  high in the HIGH and LOW states.
- `intrpt`  out  1  burst-done interrupt. Rising edge is the event; high for INTRPT_LEN cycles.

## Operation
- **States:** IDLE, HIGH, LOW, DONE.
- **IDLE, `enable`=1:**
  - Latch `half_period` into the active register `hp_act`.
  - Latch `pulse_num` into `num_act`.
  - Clear `pulse_cnt` and the phase counter, then go to HIGH.
- **HIGH:**
  - `pulse_out`=1 for `hp_act` cycles.
  - On the last cycle, go to LOW and increment `pulse_cnt` in the same cycle that `pulse_out` falls.
- **LOW:**
  - `pulse_out`=0 for `hp_act` cycles.
  - On the last cycle, if the burst is complete, go to DONE.
  - Otherwise re-sample `half_period` into `hp_act` and go to HIGH.
- **Period changes:** take effect only at a full-period boundary. A pulse never has unequal halves.
- **DONE:**
  - `pulse_out`=0, `busy`=0.
  - Remain in DONE while `enable`=1. Go to IDLE when `enable`=0.
  - A restart therefore requires `enable` to go low, then high.
- **Abort:** `enable`=0 in any state moves to IDLE on the next edge.
  - `pulse_out`=0 and `busy`=0.
  - `pulse_cnt` holds its value; it is cleared on the next start.
  - No interrupt is issued.
- **Counters:**
  - The phase counter is 32 bits, compared against `hp_act`−1.
  - `pulse_cnt` wraps from 0xFFFFFFFF to 0 in free-run.
- **Interrupt:**
  - Asserted on the DONE entry edge, held INTRPT_LEN cycles, then cleared.
  - Not retriggered while already high.
  - Cleared immediately by `enable`=0 or reset.

## Timing
- **Reset values:** `pulse_out`=0, `pulse_cnt`=0, `busy`=0, `intrpt`=0, state IDLE, `hp_act`=1, `num_act`=0.
- **Start latency:** `enable` sampled high in IDLE at edge N gives `pulse_out`=1 and `busy`=1 after edge N+1.
- **Waveform:** high exactly H cycles, low exactly H cycles, period 2H, where H = max(`hp_act`, 1).
- **Burst end:** after the last LOW cycle, on the next edge `busy` falls and `intrpt` rises in the same cycle.
- **Abort latency:** `enable` low at edge M gives `pulse_out`=0 after edge M.
- **`half_period` sampling:** only at start and at each LOW→HIGH transition. Changes at other times are ignored until then.

## Configuration
- **`PULSE_GEN_BURST_EN` defined:**
  - `pulse_num` limits the burst. A burst is complete when `pulse_cnt` = `num_act` at the end of LOW.
  - `num_act`=0 means free-run.
  - DONE and `intrpt` operate as above.
- **Not defined:**
  - `pulse_num` is ignored; generation is always free-run until `enable` drops.
  - DONE is unreachable, and `intrpt` is tied to 0.

## Test plan
- **Reset:** reset asserted for 3 cycles mid-HIGH -> all outputs 0 on the next edge; IDLE after release with `enable`=0.
- **Two-pulse burst** (burst enabled): `half_period`=3, `pulse_num`=2, `enable` raised -> `pulse_out` pattern 1,1,1,0,0,0,1,1,1,0,0,0.
  - `pulse_cnt` steps 1 then 2 on the falling edges.
  - `busy` falls and `intrpt` rises together, with `intrpt` high for 9 cycles.
- **Period change:** `half_period` changed from 4 to 2 during the first HIGH of a free-run -> first period 8 cycles, second period 4 cycles, no split pulse.
- **Abort:** `enable` dropped on the 2nd cycle of HIGH with `half_period`=5 -> `pulse_out`=0 on the next cycle, `pulse_cnt` holds, `intrpt` stays 0.
  - Re-raising `enable` restarts with `pulse_cnt`=0.
- **Zero half-period:** `half_period`=0 -> `pulse_out` toggles every cycle (period 2).
- **Free-run:** `pulse_num`=0, or macro undefined with `pulse_num`=3 -> runs indefinitely past 3 pulses, with `intrpt` never asserted.

Source files
------------

// File: rtl/power_pulse_gen.sv
// Programmable 50% duty pulse generator with optional burst length and done interrupt.
// Burst limit / DONE / intrpt are built only when PULSE_GEN_BURST_EN is defined.
module power_pulse_gen #(
  parameter int unsigned INTRPT_LEN = 9
) (
  input  logic        clkin,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] half_period,
  input  logic [31:0] pulse_num,
  output logic        pulse_out,
  output logic [31:0] pulse_cnt,
  output logic        busy,
  output logic        intrpt
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] hp_act_q, hp_act_d;
  logic [31:0] ph_q, ph_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hp_sat;
  logic        ph_last;
  logic        burst_done;
  logic        pulse_out_q, busy_q;
  logic [31:0] pulse_cnt_q;

  // hp_act always holds a value >= 1 so the terminal compare never underflows
  assign hp_sat  = (half_period == '0) ? 32'd1 : half_period;
  assign ph_last = (ph_q == hp_act_q - 32'd1);

`ifdef PULSE_GEN_BURST_EN
  logic [31:0] num_act_q, num_act_d;
  assign burst_done = (num_act_q != '0) && (cnt_q == num_act_q);
`else
  logic unused_pulse_num;
  assign unused_pulse_num = ^pulse_num;
  assign burst_done       = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    hp_act_d = hp_act_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q;
`ifdef PULSE_GEN_BURST_EN
    num_act_d = num_act_q;
`endif
    case (state_q)
      S_IDLE: if (enable) begin
        hp_act_d = hp_sat;
`ifdef PULSE_GEN_BURST_EN
        num_act_d = pulse_num;
`endif
        cnt_d    = '0;
        ph_d     = '0;
        state_d  = S_HIGH;
      end
      S_HIGH: if (ph_last) begin
        ph_d    = '0;
        cnt_d   = cnt_q + 32'd1;
        state_d = S_LOW;
      end else begin
        ph_d = ph_q + 32'd1;
      end
      S_LOW: if (ph_last) begin
        ph_d = '0;
        if (burst_done) begin
          state_d = S_DONE;
        end else begin
          hp_act_d = hp_sat;
          state_d  = S_HIGH;
        end
      end else begin
        ph_d = ph_q + 32'd1;
      end
      default: ;
    endcase
    if (!enable) begin
      state_d  = S_IDLE;
      hp_act_d = hp_act_q;
      cnt_d    = cnt_q;
    end
  end

  // Outputs are registered off the current state, so they trail the FSM by one edge,
  // except that enable low clears them on the same edge.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hp_act_q    <= 32'd1;
      ph_q        <= '0;
      cnt_q       <= '0;
      pulse_out_q <= 1'b0;
      busy_q      <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hp_act_q    <= hp_act_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      pulse_out_q <= enable && (state_q == S_HIGH);
      busy_q      <= enable && ((state_q == S_HIGH) || (state_q == S_LOW));
      pulse_cnt_q <= (enable && (state_q == S_IDLE)) ? '0 : cnt_q;
    end
  end

  assign pulse_out = pulse_out_q;
  assign busy      = busy_q;
  assign pulse_cnt = pulse_cnt_q;

`ifdef PULSE_GEN_BURST_EN
  logic        intrpt_q, intrpt_d;
  logic        done_seen_q;
  logic [31:0] icnt_q, icnt_d;

  always_comb begin
    intrpt_d = intrpt_q;
    icnt_d   = icnt_q;
    if (!enable) begin
      intrpt_d = 1'b0;
      icnt_d   = '0;
    end else if (intrpt_q) begin
      if (icnt_q == 32'(INTRPT_LEN - 1)) intrpt_d = 1'b0;
      else                               icnt_d   = icnt_q + 32'd1;
    end else if ((state_q == S_DONE) && !done_seen_q) begin
      intrpt_d = 1'b1;
      icnt_d   = '0;
    end
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      num_act_q   <= '0;
      intrpt_q    <= 1'b0;
      icnt_q      <= '0;
      done_seen_q <= 1'b0;
    end else begin
      num_act_q   <= num_act_d;
      intrpt_q    <= intrpt_d;
      icnt_q      <= icnt_d;
      done_seen_q <= (state_q == S_DONE);
    end
  end

  assign intrpt = intrpt_q;
`else
  assign intrpt = 1'b0;
`endif

endmodule
